pwm_peripheral: RTL and testbench
=================================

Name: pwm_peripheral

Overview:
- Downstream consumer of the SPI register file; turns its five 8-bit control registers into 16 output pins.
- Register map consumed:
  - 0x00 en_out[7:0] and 0x01 en_out[15:8]: per-pin output enables.
  - 0x02 en_pwm[7:0] and 0x03 en_pwm[15:8]: per-pin PWM mode.
  - 0x04 duty: common 8-bit duty cycle.
- Each enabled pin is either a static high or a ~3 kHz PWM waveform. All pins share one prescaler, one 8-bit period counter and one duty value.

Parameters:
PRESCALE, 13, system clocks per PWM count tick; legal range 1..65535. The default gives a 3328-clock period, about 3.0 kHz at 10 MHz.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en_out  input  16  {reg2,reg1}; bit i enables out[i]
en_pwm  input  16  {reg4,reg3}; bit i selects PWM (1) or static high (0) for out[i]
duty  input  8  reg5; duty cycle, high-time = duty/256 of period
out  output  16  registered pin drive
period_start  output  1  one-clock pulse when the period counter wraps to 0

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low (rst_n). When asserted:
  - pre_cnt, pwm_cnt and duty_q clear to 0.
  - out clears to 16'h0000 and period_start to 0, immediately and without a clock.
  - Release is sampled on the next clk edge.
  - Reset asserted mid-period aborts the period. After release, counting restarts at pwm_cnt=0, pre_cnt=0.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1 and wraps.
  - tick=1 in the cycle where pre_cnt==PRESCALE-1.
  - PRESCALE=1 gives tick every clock.
- Period counter: pwm_cnt is 8-bit and increments on tick. It wraps naturally 255 -> 0. Period = 256*PRESCALE clocks.
- period_start: registered. It is 1 for exactly one clock after the edge where pwm_cnt goes 255 -> 0.
- Waveform: pwm_raw = (duty_q==8'hFF) ? 1 : (pwm_cnt < duty_q).
  - duty 0x00: constant low.
  - duty 0xFF: constant high, no 1-count glitch.
  - Compare is unsigned 8-bit.
- Pin mux, registered with 1-clock latency: next_out[i] = en_out[i] & (en_pwm[i] ? pwm_raw : 1'b1).
  - en_out/en_pwm changes appear on out the clock after they change, without waiting for the period boundary.
- Inputs are already synchronous to clk (the SPI block sits in the same domain). No synchronizers are needed.
- Simultaneous events:
  - A duty change in the same cycle as the wrap takes effect per the Optional Feature rules.
  - An enable change in the same cycle as the wrap is simply the next out value.

Optional Feature:
Macro PWM_DUTY_SHADOW_EN.
- Defined:
  - duty_q is a shadow register, loaded from duty only on the edge where tick & pwm_cnt==255 (the wrap).
  - A duty write mid-period therefore affects only the next full period, so periods are never truncated or stretched.
  - A duty value present on the wrap cycle itself is captured.
- Undefined:
  - duty_q is a plain register loaded from duty every clock.
  - A change is visible on out 2 clocks after duty changes, possibly mid-period.

Decomposition:
- Package pwm_pkg:
  - PWM_CNT_W=8
  - DUTY_FULL=8'hFF
  - NUM_PINS=16
  - PRESCALE_DEFAULT=13
- Sub-module pwm_prescaler:
  - Ports: clk, rst_n, parameter PRESCALE, output tick.
  - Holds pre_cnt with a width of $clog2(PRESCALE) (min 1).
- Top holds pwm_cnt, duty_q, the pin mux and the output registers.

Test Plan:
1. Reset: drive rst_n=0 mid-operation with out=16'hFFFF -> out=0 and period_start=0 asynchronously. After release, the first period_start occurs 3328 clocks later (PRESCALE=13).
2. en_out=16'h00FF, en_pwm=16'h0000, duty=8'h80 -> out=16'h00FF exactly 1 clock after the inputs settle, constant thereafter.
3. en_out=16'h0001, en_pwm=16'h0001, duty=8'h80 -> out[0] high 1664 clocks, low 1664 clocks, period 3328. Other bits stay 0.
4. Same pin with duty=8'h00, then duty=8'hFF -> out[0] constant 0 for a full period, then constant 1 for a full period with no low pulse at wrap.
5. With PWM_DUTY_SHADOW_EN: change duty 0x40 -> 0xC0 at pwm_cnt=0x20 -> the current period keeps high-time 0x40*13=832 clocks; the next period has 0xC0*13=2496.
   Without the macro: the same stimulus lengthens the current high pulse to 2496 clocks.
6. en_out=16'hFFFF, en_pwm=16'hAAAA, duty=8'h40 -> odd pins follow the PWM waveform in phase, even pins stay high. Clearing en_out[15:8] forces out[15:8]=0 next clock.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, constants and the pin-mux helper for the PWM peripheral.
package pwm_pkg;
  localparam int PWM_CNT_W = 8;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
  localparam int NUM_PINS = 16;
  localparam int PRESCALE_DEFAULT = 13;
  function automatic logic [NUM_PINS-1:0] pin_mux(
    input logic [NUM_PINS-1:0] en_out,
    input logic [NUM_PINS-1:0] en_pwm,
    input logic raw
  );
    return en_out & (~en_pwm | {NUM_PINS{raw}});
  endfunction
endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: divides clk by PRESCALE, tick is high in the last count of each cycle.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [W-1:0] pre_cnt;
  assign tick = pre_cnt == W'(PRESCALE - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pre_cnt <= '0;
    else pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16 pins of static-high or shared-duty PWM drive from the SPI control registers.
// Define PWM_DUTY_SHADOW_EN to latch duty only at the period wrap.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PINS-1:0]  en_out,
  input  logic [NUM_PINS-1:0]  en_pwm,
  input  logic [PWM_CNT_W-1:0] duty,
  output logic [NUM_PINS-1:0]  out,
  output logic                 period_start
);
  logic tick, wrap, pwm_raw;
  logic [PWM_CNT_W-1:0] pwm_cnt, duty_q;
  pwm_prescaler #(.PRESCALE(PRESCALE)) u_pre (.clk(clk), .rst_n(rst_n), .tick(tick));
  assign wrap = tick && pwm_cnt == '1;
  // Full scale is forced high so the pin never drops for the count where pwm_cnt==255.
  assign pwm_raw = duty_q == DUTY_FULL ? 1'b1 : pwm_cnt < duty_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pwm_cnt      <= '0;
      duty_q       <= '0;
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      pwm_cnt      <= tick ? pwm_cnt + 1'b1 : pwm_cnt;
`ifdef PWM_DUTY_SHADOW_EN
      duty_q       <= wrap ? duty : duty_q;
`else
      duty_q       <= duty;
`endif
      out          <= pin_mux(en_out, en_pwm, pwm_raw);
      period_start <= wrap;
    end
endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: table vectors for static pin-mux combinations plus timed
// sequences for reset, period, duty extremes, mid-period duty change and mixed pins.
module tb_pwm_peripheral;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] en_out = '0, en_pwm = '0, out;
  logic [7:0]  duty = '0;
  logic        period_start;
  int total = 0, bad = 0;

  pwm_peripheral dut (
    .clk(clk), .rst_n(rst_n), .en_out(en_out), .en_pwm(en_pwm),
    .duty(duty), .out(out), .period_start(period_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] eo;
    logic [15:0] ep;
    logic [7:0]  d;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ps();
    int n = 0;
    do begin
      step();
      n++;
    end while (!period_start && n < 4000);
    if (!period_start) chk("period_start_timeout", 32'(n), 32'd3328);
  endtask

  task automatic set_duty_sync(input logic [7:0] d);
    duty = d;
    wait_ps();
    step();
  endtask

  task automatic count_first_ps(input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (!period_start && n < 4000);
    chk(name, 32'(n), 32'd3328);
  endtask

  initial begin
    int hi, hi2, misc_bad, ps_n;
    logic [7:0] cur_duty;
    vecs[0] = '{16'h00FF, 16'h0000, 8'h80, 16'h00FF};
    vecs[1] = '{16'hFFFF, 16'h0000, 8'h80, 16'hFFFF};
    vecs[2] = '{16'h1234, 16'h0000, 8'h80, 16'h1234};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 8'hFF, 16'hFFFF};
    vecs[4] = '{16'hF0F0, 16'h0F0F, 8'hFF, 16'hF0F0};
    vecs[5] = '{16'hFFFF, 16'hAAAA, 8'h00, 16'h5555};
    vecs[6] = '{16'h00FF, 16'h00F0, 8'h00, 16'h000F};
    vecs[7] = '{16'h0000, 16'hFFFF, 8'h00, 16'h0000};

    // Reset state and first period after release
    #12;
    chk("reset_out", 32'(out), 32'h0);
    chk("reset_ps", 32'(period_start), 32'h0);
    rst_n = 1'b1;
    count_first_ps("first_ps_after_release");

    // Asynchronous reset mid-operation
    en_out = 16'hFFFF;
    en_pwm = 16'h0000;
    step();
    chk("static_all_high", 32'(out), 32'hFFFF);
    repeat (500) step();
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_out", 32'(out), 32'h0);
    chk("async_reset_ps", 32'(period_start), 32'h0);
    #1 rst_n = 1'b1;
    count_first_ps("ps_after_midperiod_reset");

    // Table vectors; duty is resynchronised to a period boundary when it changes
    cur_duty = 8'h80;
    set_duty_sync(cur_duty);
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].d != cur_duty) begin
        cur_duty = vecs[i].d;
        set_duty_sync(cur_duty);
      end
      en_out = vecs[i].eo;
      en_pwm = vecs[i].ep;
      step();
      chk($sformatf("vec%0d", i), 32'(out), 32'(vecs[i].exp));
    end

    // 50% duty on pin 0 over one full period
    en_out = 16'h0001;
    en_pwm = 16'h0001;
    set_duty_sync(8'h80);
    hi = 0; misc_bad = 0; ps_n = 0;
    for (int i = 0; i < 3328; i++) begin
      hi += int'(out[0]);
      if (out[15:1] != 0) misc_bad++;
      if (period_start) ps_n++;
      step();
    end
    chk("duty80_high", 32'(hi), 32'd1664);
    chk("duty80_other_pins", 32'(misc_bad), 32'd0);
    chk("duty80_one_ps_per_period", 32'(ps_n), 32'd1);

    // Duty extremes across a full period including the wrap
    set_duty_sync(8'h00);
    hi = 0;
    for (int i = 0; i < 3328; i++) begin hi += int'(out[0]); step(); end
    chk("duty00_high", 32'(hi), 32'd0);
    set_duty_sync(8'hFF);
    hi = 0;
    for (int i = 0; i < 3328; i++) begin hi += int'(out[0]); step(); end
    chk("dutyFF_high", 32'(hi), 32'd3328);

    // Duty change at pwm_cnt=0x20
    set_duty_sync(8'h40);
    wait_ps();
    hi = 0; hi2 = 0;
    for (int i = 0; i < 6656; i++) begin
      if (i == 416) duty = 8'hC0;
      if (i < 3328) hi += int'(out[0]); else hi2 += int'(out[0]);
      step();
    end
`ifdef PWM_DUTY_SHADOW_EN
    chk("midperiod_change_cur", 32'(hi), 32'd832);
`else
    chk("midperiod_change_cur", 32'(hi), 32'd2496);
`endif
    chk("midperiod_change_next", 32'(hi2), 32'd2496);

    // Mixed static and PWM pins
    en_out = 16'hFFFF;
    en_pwm = 16'hAAAA;
    set_duty_sync(8'h40);
    hi = 0; misc_bad = 0;
    for (int i = 0; i < 3328; i++) begin
      hi += int'(out[1]);
      if ((out & 16'h5555) != 16'h5555) misc_bad++;
      if ((out & 16'hAAAA) != 16'h0000 && (out & 16'hAAAA) != 16'hAAAA) misc_bad++;
      step();
    end
    chk("mixed_pwm_high", 32'(hi), 32'd832);
    chk("mixed_phase_static", 32'(misc_bad), 32'd0);
    en_out = 16'h00FF;
    step();
    chk("mixed_upper_cleared", 32'(out[15:8]), 32'h0);
    chk("mixed_lower_static", 32'(out & 16'h0055), 32'h0055);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
